// File: rtl/riscv_defs_pkg.sv
// Shared RV32IM execute-stage definitions: aluCtrl codes, mul/div FSM
// state encodings and forwarding-select encodings.
package riscv_defs_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned ST_W   = 2;

    // RV32I ALU operations (aluCtrl[4] = 0)
    localparam logic [CTRL_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [CTRL_W-1:0] ALU_SLL   = 5'd2;
    localparam logic [CTRL_W-1:0] ALU_SLT   = 5'd3;
    localparam logic [CTRL_W-1:0] ALU_SLTU  = 5'd4;
    localparam logic [CTRL_W-1:0] ALU_XOR   = 5'd5;
    localparam logic [CTRL_W-1:0] ALU_SRL   = 5'd6;
    localparam logic [CTRL_W-1:0] ALU_SRA   = 5'd7;
    localparam logic [CTRL_W-1:0] ALU_OR    = 5'd8;
    localparam logic [CTRL_W-1:0] ALU_AND   = 5'd9;
    localparam logic [CTRL_W-1:0] ALU_PASSB = 5'd10;

    // RV32M operations (aluCtrl[4:3] = 2'b10)
    localparam logic [CTRL_W-1:0] M_MUL    = 5'd16;
    localparam logic [CTRL_W-1:0] M_MULH   = 5'd17;
    localparam logic [CTRL_W-1:0] M_MULHSU = 5'd18;
    localparam logic [CTRL_W-1:0] M_MULHU  = 5'd19;
    localparam logic [CTRL_W-1:0] M_DIV    = 5'd20;
    localparam logic [CTRL_W-1:0] M_DIVU   = 5'd21;
    localparam logic [CTRL_W-1:0] M_REM    = 5'd22;
    localparam logic [CTRL_W-1:0] M_REMU   = 5'd23;

    // Iterative unit FSM states
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Forwarding source select
    localparam logic [FWD_W-1:0] FWD_IDEX  = 2'd0;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'd1;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'd2;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] ex_rd,
        input logic             ex_we,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_we
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
            return FWD_EXMEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return FWD_MEMWB;
        end
        return FWD_IDEX;
    endfunction

    function automatic logic is_m_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand
// magnitudes, sign fix-up applied to the final value.
// Ports: clk, rst (async active-low), start (M op present), op (low 3 bits
// of aluCtrl), op_a/op_b (forwarded operands), busy (stall request),
// done (result valid this cycle), result.
module ex_muldiv
    import riscv_defs_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  dsr;
    logic             neg_q;
    logic             neg_r;

    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN:0]    div_trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic             capture;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    busy      = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(MD_CYCLES - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign capture = (state == ST_IDLE) && start;

    // Operand signedness and magnitudes at capture
    always_comb begin
        a_signed = (op == M_MULH[2:0]) || (op == M_MULHSU[2:0]) ||
                   (op == M_DIV[2:0])  || (op == M_REM[2:0]);
        b_signed = (op == M_MULH[2:0]) || (op == M_DIV[2:0]) ||
                   (op == M_REM[2:0]);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? (~op_a + XLEN'(1)) : op_a;
        b_mag    = b_neg ? (~op_b + XLEN'(1)) : op_b;
    end

    // One iteration step for each algorithm
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_trial = div_shift - {1'b0, dsr};
    end

    // Datapath registers: hi/lo form {product} or {remainder, quotient}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (capture) begin
            cnt  <= '0;
            op_q <= op;
            hi   <= '0;
            if (op[2]) begin
                lo    <= a_mag;
                dsr   <= b_mag;
                // divide by zero leaves the all-ones quotient unsigned
                neg_q <= (a_neg ^ b_neg) && (op_b != '0);
                neg_r <= a_neg;
            end else begin
                lo    <= b_mag;
                dsr   <= a_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
            if (op_q[2]) begin
                hi <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~div_trial[XLEN]};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up and word select
    always_comb begin
        prod   = neg_q ? (~{hi, lo} + (2*XLEN)'(1)) : {hi, lo};
        quo    = neg_q ? (~lo + XLEN'(1)) : lo;
        rem    = neg_r ? (~hi + XLEN'(1)) : hi;
        result = '0;
        case (op_q)
            3'd0:                   result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:             result = quo;
            default:                result = rem;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand forwarding from EX/MEM and MEM/WB,
// single-cycle ALU, iterative mul/div with upstream stall and EX/MEM bubble.
// Ports: ID/EX datapath (readData1/2, immediate, rs1, rs2, rd) and control
// (regWrite, memtoReg, memWrite, memRead, aluSrc, aluCtrl); forwarding
// sources (exmem*, memwb*); outputs to EX/MEM (aluResult, storeData, outRd,
// out* control) and stall.
module ex_stage
    import riscv_defs_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   readData1,
    input  logic [XLEN-1:0]   readData2,
    input  logic [XLEN-1:0]   immediate,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [REG_W-1:0]  rd,
    input  logic              regWrite,
    input  logic              memtoReg,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic              aluSrc,
    input  logic [CTRL_W-1:0] aluCtrl,
    input  logic [REG_W-1:0]  exmemRd,
    input  logic              exmemRegWrite,
    input  logic [XLEN-1:0]   exmemAluResult,
    input  logic [REG_W-1:0]  memwbRd,
    input  logic              memwbRegWrite,
    input  logic [XLEN-1:0]   memwbWriteData,
    output logic [XLEN-1:0]   aluResult,
    output logic [XLEN-1:0]   storeData,
    output logic [REG_W-1:0]  outRd,
    output logic              outRegWrite,
    output logic              outMemtoReg,
    output logic              outMemWrite,
    output logic              outMemRead,
    output logic              stall
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [FWD_W-1:0] sel_a;
    logic [FWD_W-1:0] sel_b;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  fwd_b;
    logic [XLEN-1:0]  op_b;
    logic [SH_W-1:0]  shamt;
    logic [XLEN-1:0]  alu_res;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [XLEN-1:0]  md_result;

    // Forwarding muxes
    always_comb begin
        sel_a = fwd_sel(rs1, exmemRd, exmemRegWrite, memwbRd, memwbRegWrite);
        sel_b = fwd_sel(rs2, exmemRd, exmemRegWrite, memwbRd, memwbRegWrite);
        case (sel_a)
            FWD_EXMEM: op_a = exmemAluResult;
            FWD_MEMWB: op_a = memwbWriteData;
            default:   op_a = readData1;
        endcase
        case (sel_b)
            FWD_EXMEM: fwd_b = exmemAluResult;
            FWD_MEMWB: fwd_b = memwbWriteData;
            default:   fwd_b = readData2;
        endcase
        op_b  = aluSrc ? immediate : fwd_b;
        shamt = op_b[SH_W-1:0];
    end

    // Single-cycle RV32I ALU; M codes and undefined codes yield 0
    always_comb begin
        alu_res = '0;
        case (aluCtrl)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    // Gate start with reset so stall falls as soon as reset asserts
    assign md_start = is_m_op(aluCtrl) && rst;

    ex_muldiv #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (aluCtrl[2:0]),
        .op_a   (op_a),
        .op_b   (fwd_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Output select and bubble insertion while stalled
    always_comb begin
        stall       = md_busy;
        storeData   = fwd_b;
        aluResult   = '0;
        outRd       = '0;
        outRegWrite = 1'b0;
        outMemtoReg = 1'b0;
        outMemWrite = 1'b0;
        outMemRead  = 1'b0;
        if (!md_busy) begin
            aluResult   = md_done ? md_result : alu_res;
            outRd       = rd;
            outRegWrite = regWrite;
            outMemtoReg = memtoReg;
            outMemWrite = memWrite;
            outMemRead  = memRead;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: forwarding, ALU, mul/div latency and
// corner cases, operand capture, back-to-back ops and reset abort.
module tb_ex_stage;
    import riscv_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] readData1, readData2, immediate;
    logic [4:0]  rs1, rs2, rd;
    logic        regWrite, memtoReg, memWrite, memRead, aluSrc;
    logic [4:0]  aluCtrl;
    logic [4:0]  exmemRd;
    logic        exmemRegWrite;
    logic [31:0] exmemAluResult;
    logic [4:0]  memwbRd;
    logic        memwbRegWrite;
    logic [31:0] memwbWriteData;
    logic [31:0] aluResult, storeData;
    logic [4:0]  outRd;
    logic        outRegWrite, outMemtoReg, outMemWrite, outMemRead, stall;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .readData1(readData1), .readData2(readData2), .immediate(immediate),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .regWrite(regWrite), .memtoReg(memtoReg), .memWrite(memWrite),
        .memRead(memRead), .aluSrc(aluSrc), .aluCtrl(aluCtrl),
        .exmemRd(exmemRd), .exmemRegWrite(exmemRegWrite),
        .exmemAluResult(exmemAluResult),
        .memwbRd(memwbRd), .memwbRegWrite(memwbRegWrite),
        .memwbWriteData(memwbWriteData),
        .aluResult(aluResult), .storeData(storeData), .outRd(outRd),
        .outRegWrite(outRegWrite), .outMemtoReg(outMemtoReg),
        .outMemWrite(outMemWrite), .outMemRead(outMemRead), .stall(stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (c)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a << b[4:0];
            5'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:    return (a < b) ? 32'd1 : 32'd0;
            5'd5:    return a ^ b;
            5'd6:    return a >> b[4:0];
            5'd7:    return sa >>> b[4:0];
            5'd8:    return a | b;
            5'd9:    return a & b;
            5'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (c)
            5'd16: begin p = ua * ub; return p[31:0];  end
            5'd17: begin p = sa * sb; return p[63:32]; end
            5'd18: begin p = sa * ub; return p[63:32]; end
            5'd19: begin p = ua * ub; return p[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            5'd21:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic zero_inputs();
        readData1 = '0; readData2 = '0; immediate = '0;
        rs1 = '0; rs2 = '0; rd = '0;
        regWrite = 0; memtoReg = 0; memWrite = 0; memRead = 0; aluSrc = 0;
        aluCtrl = '0;
        exmemRd = '0; exmemRegWrite = 0; exmemAluResult = '0;
        memwbRd = '0; memwbRegWrite = 0; memwbWriteData = '0;
    endtask

    // Pop the expected result at the next sample point and compare
    task automatic sample_result(input string tag);
        @(negedge clk);
        check(tag, aluResult, exp_q.pop_front());
    endtask

    task automatic alu_case(input string tag, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        zero_inputs();
        aluCtrl = c; readData1 = a; readData2 = b; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        exp_q.push_back(ref_alu(c, a, b));
        sample_result(tag);
    endtask

    // Issue an M op and follow it through the stall; fwd routes rs1 via
    // EX/MEM at entry and then corrupts both rs1 sources during RUN.
    task automatic md_case(input string tag, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b, input bit fwd);
        int cnt;
        logic ctl_bad;
        @(posedge clk); #1;
        zero_inputs();
        aluCtrl = c; readData2 = b; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd7;
        regWrite = 1; memtoReg = 1; memWrite = 1; memRead = 1;
        if (fwd) begin
            exmemRd = 5'd1; exmemRegWrite = 1; exmemAluResult = a; readData1 = ~a;
        end else begin
            readData1 = a;
        end
        exp_q.push_back(ref_md(c, a, b));
        cnt = 0;
        ctl_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            cnt++;
            if (outRegWrite || outMemtoReg || outMemWrite || outMemRead ||
                outRd != 0 || aluResult != 0) ctl_bad = 1;
            if (fwd && cnt == 2) begin
                exmemAluResult = 32'hDEAD_BEEF; readData1 = 32'h0BAD_F00D;
            end
        end
        check({tag, "_timeout"}, 32'(stall), 32'd0);
        check({tag, "_stall_cycles"}, cnt, 32'd33);
        check({tag, "_bubble"}, 32'(ctl_bad), 32'd0);
        check({tag, "_result"}, aluResult, exp_q.pop_front());
        check({tag, "_rd"}, 32'(outRd), 32'd7);
        check({tag, "_we"}, 32'(outRegWrite), 32'd1);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        zero_inputs();
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_result", aluResult, 32'd0);
        check("reset_ctl", {27'd0, outRegWrite, outMemtoReg, outMemWrite, outMemRead, 1'b0}, 32'd0);
        check("reset_rd", 32'(outRd), 32'd0);
        rst = 1'b1;

        // Forwarding priority and x0 exclusion
        @(posedge clk); #1;
        zero_inputs();
        aluCtrl = ALU_ADD; aluSrc = 1; immediate = 32'd1; rs1 = 5'd5; readData1 = 32'h33;
        exmemRd = 5'd5; exmemRegWrite = 1; exmemAluResult = 32'h11;
        memwbRd = 5'd5; memwbRegWrite = 1; memwbWriteData = 32'h22;
        rs2 = 5'd5; readData2 = 32'h44;
        exp_q.push_back(32'h12);
        sample_result("fwd_exmem_prio");
        check("fwd_store_exmem", storeData, 32'h11);

        @(posedge clk); #1;
        exmemRd = 5'd0;
        exp_q.push_back(32'h23);
        sample_result("fwd_memwb");
        check("fwd_store_memwb", storeData, 32'h22);

        @(posedge clk); #1;
        rs1 = 5'd0; rs2 = 5'd0; memwbRd = 5'd0;
        exp_q.push_back(32'h34);
        sample_result("fwd_none_x0");
        check("fwd_store_none", storeData, 32'h44);

        // ALU sweep
        alu_case("sub_wrap",  ALU_SUB,   32'd0,          32'd1);
        alu_case("sra",       ALU_SRA,   32'h8000_0000,  32'd4);
        alu_case("sltu",      ALU_SLTU,  32'd1,          32'hFFFF_FFFF);
        alu_case("slt",       ALU_SLT,   32'd1,          32'hFFFF_FFFF);
        alu_case("sll",       ALU_SLL,   32'h0000_00F1,  32'h0000_0024);
        alu_case("srl",       ALU_SRL,   32'h8000_0000,  32'd31);
        alu_case("xor",       ALU_XOR,   32'hA5A5_0F0F,  32'h0FF0_FFFF);
        alu_case("or",        ALU_OR,    32'h1200_0034,  32'h0056_7800);
        alu_case("and",       ALU_AND,   32'hF0F0_F0F0,  32'h3C3C_3C3C);
        alu_case("add_wrap",  ALU_ADD,   32'hFFFF_FFFF,  32'd2);
        alu_case("passb",     ALU_PASSB, 32'h1111_1111,  32'hCAFE_0001);
        alu_case("undef",     5'd11,     32'h1234_5678,  32'h1);

        // Multiply latency and signedness
        md_case("mulh",   M_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        md_case("mulhu",  M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        md_case("mulhsu", M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        md_case("mul",    M_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Division corners
        md_case("div_by0",  M_DIV,  32'd7,          32'd0,         0);
        md_case("rem_by0",  M_REM,  32'd7,          32'd0,         0);
        md_case("div_ovf",  M_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 0);
        md_case("rem_ovf",  M_REM,  32'h8000_0000,  32'hFFFF_FFFF, 0);
        md_case("div_neg",  M_DIV,  32'hFFFF_FFF9,  32'd2,         0);
        md_case("rem_neg",  M_REM,  32'hFFFF_FFF9,  32'd2,         0);
        md_case("divu",     M_DIVU, 32'hFFFF_FFF9,  32'd10,        0);

        // Operand capture, then back-to-back M op
        md_case("mul_cap",  M_MUL,  32'd6,          32'd7,         1);
        md_case("mul_b2b",  M_MUL,  32'hFFFF_FFFE,  32'd3,         0);

        // Reset abort mid-RUN
        @(posedge clk); #1;
        zero_inputs();
        aluCtrl = M_DIVU; readData1 = 32'd100; readData2 = 32'd7; rs1 = 5'd1; rs2 = 5'd2;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) cnt++;
            if (cnt == 11) break;
        end
        check("rst_pre_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_stall_drop", 32'(stall), 32'd0);
        check("rst_result", aluResult, 32'd0);
        @(posedge clk); #1;
        zero_inputs();
        aluCtrl = ALU_ADD; readData1 = 32'd3; aluSrc = 1; immediate = 32'd4;
        #2 rst = 1'b1;
        exp_q.push_back(32'd7);
        sample_result("rst_idle_alu");
        check("rst_idle_stall", 32'(stall), 32'd0);
        md_case("divu_after_rst", M_DIVU, 32'd100, 32'd7, 0);
        md_case("remu_after_rst", M_REMU, 32'd100, 32'd7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register. Consumes its datapath and control outputs.
- Resolves RAW forwarding from EX/MEM and MEM/WB, executes RV32I ALU ops in one cycle, and runs RV32M mul/div on an iterative unit.
- While the iterative unit is busy it asserts stall, which freezes PC/IF-ID/ID-EX and forces a bubble into EX/MEM.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterative RUN cycles; fixed, must equal XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- readData1  in  XLEN  rs1 value from ID/EX.
- readData2  in  XLEN  rs2 value from ID/EX.
- immediate  in  XLEN  sign-extended immediate.
- rs1  in  5  source register index; rs2 is the same, for the second source.
- rd  in  5  destination register index.
- regWrite, memtoReg, memWrite, memRead  in  1 each  passthrough control.
- aluSrc  in  1  1 selects immediate as operand B.
- aluCtrl  in  5  operation code (package).
- exmemRd  in  5  EX/MEM destination; exmemRegWrite  in  1; exmemAluResult  in  XLEN.
- memwbRd  in  5  MEM/WB destination; memwbRegWrite  in  1; memwbWriteData  in  XLEN.
- aluResult  out  XLEN  result to EX/MEM.
- storeData  out  XLEN  forwarded rs2 value for stores.
- outRd  out  5  destination passthrough.
- outRegWrite, outMemtoReg, outMemWrite, outMemRead  out  1 each  gated control passthrough.
- stall  out  1  hold upstream; bubble EX/MEM.

Behaviour:
- Forwarding, per source, combinational:
  - EX/MEM hit when exmemRegWrite and exmemRd != 0 and exmemRd == rsX.
  - Else MEM/WB hit under the same rule.
  - Else use the ID/EX value. EX/MEM has priority when both hit.
- Operand B = aluSrc ? immediate : forwarded rs2. storeData = forwarded rs2, always.
- ALU (aluCtrl[4]=0), combinational:
  - Codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - Shifts use B[4:0]. Wrap-around is modulo 2^XLEN.
  - Undefined codes give 0.
- M ops (aluCtrl[4]=1): MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- M-op FSM: IDLE, RUN, DONE.
  - IDLE with an M op present: capture forwarded operands and op into the unit, load counter = 0, go to RUN. stall=1 in this cycle.
  - RUN: one shift-add/restoring-subtract step per cycle, counter++. stall=1. Leave after counter == MD_CYCLES-1.
  - DONE: stall=0 and aluResult = unit result. EX/MEM captures it. Unconditionally return to IDLE, with no re-capture even though ID/EX still holds the same op.
  - Total: stall high for MD_CYCLES+1 = 33 cycles; the op occupies EX for 34 cycles; the result is visible in the DONE cycle.
  - Operands are captured at entry because forwarding sources drain during the stall.
  - Back-to-back M op: the following IDLE cycle captures the next op.
- Signedness: MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned. MUL returns the low word; MULH* return the high word.
- Division corner cases, with fixed latency (no early-out):
  - Divide by zero: quotient = all ones (DIVU and DIV); remainder = dividend.
  - Overflow, -2^31 / -1: quotient = -2^31; remainder = 0.
- Gating while stall=1: outRegWrite, outMemWrite, outMemRead, outMemtoReg are forced to 0 (bubble). outRd and aluResult are don't-care but driven as 0.
- Reset, asynchronous and active-low: FSM goes to IDLE, counter and unit registers go to 0, stall = 0.
  - All outputs are combinational from inputs plus state, so with zero control inputs the outputs read 0.
  - Reset mid-RUN aborts the op immediately; no result is emitted.

Decomposition:
- Shared header riscv_defs holds the aluCtrl code constants, FSM state encodings, and the forwarding-select encodings (FWD_IDEX 0, FWD_MEMWB 1, FWD_EXMEM 2).
- One natural sub-module: ex_muldiv, containing the FSM, counter, and shift registers, with a start/op/opA/opB/busy/done/result interface. Forwarding and the ALU stay in ex_stage.

Test Plan:
- Forwarding priority: rs1=5, exmemRd=5 (regWrite=1, result 0x11), memwbRd=5 (data 0x22), ADD with B=1 -> aluResult 0x12. Repeat with exmemRd=0 as rd, and with rs=0 -> no forward.
- ALU sweep: SUB 0 - 1 -> 0xFFFFFFFF. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 < 0xFFFFFFFF -> 1. SLT the same pair -> 0.
- MUL latency: MULH 0xFFFFFFFF × 0xFFFFFFFF -> stall high exactly 33 cycles; DONE result 0x00000000. MULHU of the same pair -> 0xFFFFFFFE. Control outputs are 0 during the stall.
- Division corners: DIV 7/0 -> 0xFFFFFFFF. REM 7/0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, with REM -> 0. DIV -7/2 -> 0xFFFFFFFD, with REM -> 0xFFFFFFFF.
- Operand capture: MUL whose rs1 is forwarded from EX/MEM at entry, with the EX/MEM inputs changed during RUN -> result uses the captured value. A back-to-back second MUL -> a second 33-cycle stall.
- Reset in RUN cycle 10 -> stall drops asynchronously and the FSM is in IDLE. The next M op yields a correct result with a full 33-cycle stall.
